mux_arb_reg: RTL and testbench

Parametrised N-input, WIDTH-bit registered multiplexer with built-in arbitration and valid/ready handshakes. It replaces hard-wired 2:1 select muxes wherever several datapath sources compete for one sink, such as the register-file write port or the memory request path. Selection is made internally by fixed-priority or round-robin arbitration rather than by an external select line. The result is held in an output register until the sink accepts it.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/mux_arb_reg.sv | 80 ++++++++
 tb/tb_mux_arb_reg.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated registered multiplexer family.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest channel count the mask helper supports, and its pointer width
    localparam int unsigned MUX_MAX_N = 64;
    localparam int unsigned MUX_PTRW  = 6;

    // Cyclic priority mask: bits at or above ptr are eligible in the first search pass
    function automatic logic [MUX_MAX_N-1:0] rr_mask(input logic [MUX_PTRW-1:0] ptr);
        logic [MUX_MAX_N-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MUX_MAX_N; i++) begin
            mask[i] = (MUX_PTRW'(i) >= ptr);
        end
        return mask;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational fixed-priority / round-robin picker producing a one-hot grant and its index.
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    // Search requests at/after ptr first; fall back to the full set to wrap around
    always_comb begin
        mask    = '1;
        masked  = '0;
        pool    = '0;
        gnt     = '0;
        gnt_idx = '0;
        if (mode == MODE_RR) begin
            mask = N'(rr_mask(MUX_PTRW'(ptr)));
        end
        masked = req & mask;
        pool   = (|masked) ? masked : req;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (pool[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-input registered multiplexer with internal arbitration and valid/ready handshakes.
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel
);

    logic [SELW-1:0]  ptr;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [SELW-1:0]  gnt_idx;
    logic             can_load;
    logic             in_xfer;
    logic [WIDTH-1:0] sel_data;

    // Requests are masked during reset so nothing is granted while held in reset
    assign req      = in_valid & {N{rst_n}};
    assign can_load = !out_valid || out_ready;
    assign in_ready = gnt & {N{can_load}};
    assign in_xfer  = can_load && (|gnt);

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .mode    (mode),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // One-hot data mux driven by the grant, feeding only the output register
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load on input transfer, drain on output transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner, wrapping at N-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (in_xfer && (mode == MODE_RR)) begin
            ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench for mux_arb_reg: N=4/WIDTH=32 and N=3/WIDTH=8 instances.
module tb_mux_arb_reg;

    logic         clk;
    logic         rst_n;

    logic         mode_a;
    logic [3:0]   in_valid_a;
    logic [127:0] in_data_a;
    logic [3:0]   in_ready_a;
    logic         out_valid_a;
    logic         out_ready_a;
    logic [31:0]  out_data_a;
    logic [1:0]   out_sel_a;

    logic         mode_b;
    logic [2:0]   in_valid_b;
    logic [23:0]  in_data_b;
    logic [2:0]   in_ready_b;
    logic         out_valid_b;
    logic         out_ready_b;
    logic [7:0]   out_data_b;
    logic [1:0]   out_sel_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic        ma_valid;
    logic [31:0] ma_data;
    int          ma_sel;
    int          ma_ptr;
    logic        mb_valid;
    logic [7:0]  mb_data;
    int          mb_sel;
    int          mb_ptr;

    typedef struct {
        logic        mode;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  ready;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  os;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vecs [21];

    mux_arb_reg #(.WIDTH(32), .N(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_a),
        .in_valid  (in_valid_a),
        .in_data   (in_data_a),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a),
        .out_sel   (out_sel_a)
    );

    mux_arb_reg #(.WIDTH(8), .N(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_b),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .out_sel   (out_sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Winner = first requesting channel scanning cyclically from the start point
    function automatic int pick(input logic [3:0] v, input int n, input logic m, input int p);
        int s;
        s = m ? p : 0;
        for (int k = 0; k < n; k++) begin
            if (v[(s + k) % n]) return (s + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready_a();
        int g;
        g = pick(in_valid_a, 4, mode_a, ma_ptr);
        if (rst_n && g >= 0 && (!ma_valid || out_ready_a)) return 4'd1 << g;
        return 4'd0;
    endfunction

    function automatic logic [2:0] exp_ready_b();
        int g;
        g = pick({1'b0, in_valid_b}, 3, mode_b, mb_ptr);
        if (rst_n && g >= 0 && (!mb_valid || out_ready_b)) return 3'd1 << g;
        return 3'd0;
    endfunction

    task automatic reset_models();
        ma_valid = 1'b0; ma_data = '0; ma_sel = 0; ma_ptr = 0;
        mb_valid = 1'b0; mb_data = '0; mb_sel = 0; mb_ptr = 0;
    endtask

    task automatic update_models();
        int g;
        if (!rst_n) begin
            reset_models();
            return;
        end
        g = pick(in_valid_a, 4, mode_a, ma_ptr);
        if (g >= 0 && (!ma_valid || out_ready_a)) begin
            ma_valid = 1'b1;
            ma_data  = in_data_a[g*32 +: 32];
            ma_sel   = g;
            if (mode_a) ma_ptr = (g + 1) % 4;
        end else if (ma_valid && out_ready_a) begin
            ma_valid = 1'b0;
        end
        g = pick({1'b0, in_valid_b}, 3, mode_b, mb_ptr);
        if (g >= 0 && (!mb_valid || out_ready_b)) begin
            mb_valid = 1'b1;
            mb_data  = in_data_b[g*8 +: 8];
            mb_sel   = g;
            if (mode_b) mb_ptr = (g + 1) % 3;
        end else if (mb_valid && out_ready_b) begin
            mb_valid = 1'b0;
        end
    endtask

    // One clock with inputs already driven: check ready before the edge, outputs after
    task automatic cycle(input string tag);
        logic [3:0] ra;
        logic [2:0] rb;
        #1;
        ra = exp_ready_a();
        rb = exp_ready_b();
        check({tag, "_ready_a"}, 64'(in_ready_a), 64'(ra));
        check({tag, "_ready_b"}, 64'(in_ready_b), 64'(rb));
        @(posedge clk);
        #1;
        update_models();
        check({tag, "_valid_a"}, 64'(out_valid_a), 64'(ma_valid));
        check({tag, "_data_a"},  64'(out_data_a),  64'(ma_data));
        check({tag, "_sel_a"},   64'(out_sel_a),   64'(ma_sel));
        check({tag, "_ptr_a"},   64'(dut_a.ptr),   64'(ma_ptr));
        check({tag, "_valid_b"}, 64'(out_valid_b), 64'(mb_valid));
        check({tag, "_data_b"},  64'(out_data_b),  64'(mb_data));
        check({tag, "_sel_b"},   64'(out_sel_b),   64'(mb_sel));
        check({tag, "_ptr_b"},   64'(dut_b.ptr),   64'(mb_ptr));
        check({tag, "_ptr_b_range"}, 64'(dut_b.ptr < 2'd3), 64'(1));
    endtask

    task automatic set_a(input logic m, input logic [3:0] v, input logic r);
        mode_a = m; in_valid_a = v; out_ready_a = r;
    endtask

    localparam logic [127:0] DATA_A = {32'h33333333, 32'h22222222, 32'h11111111, 32'h0F0F0F0F};

    initial begin
        vecs[0]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 32'h11111111, 2'd1, 2'd0};
        vecs[1]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 32'h33333333, 2'd3, 2'd0};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h33333333, 2'd3, 2'd0};
        vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h0F0F0F0F, 2'd0, 2'd1};
        vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h11111111, 2'd1, 2'd2};
        vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'h22222222, 2'd2, 2'd3};
        vecs[6]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'h33333333, 2'd3, 2'd0};
        vecs[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h0F0F0F0F, 2'd0, 2'd1};
        vecs[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h11111111, 2'd1, 2'd2};
        vecs[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'h22222222, 2'd2, 2'd3};
        vecs[10] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'h33333333, 2'd3, 2'd0};
        vecs[11] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h33333333, 2'd3, 2'd0};
        vecs[12] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 32'h22222222, 2'd2, 2'd0};
        vecs[13] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 32'h22222222, 2'd2, 2'd0};
        vecs[14] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 32'h0F0F0F0F, 2'd0, 2'd0};
        vecs[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0F0F0F0F, 2'd0, 2'd0};
        vecs[16] = '{1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'h11111111, 2'd1, 2'd2};
        vecs[17] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'h11111111, 2'd1, 2'd2};
        vecs[18] = '{1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1, 32'h22222222, 2'd2, 2'd3};
        vecs[19] = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 32'h0F0F0F0F, 2'd0, 2'd1};
        vecs[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0F0F0F0F, 2'd0, 2'd1};

        rst_n = 1'b0;
        set_a(1'b0, 4'b0000, 1'b0);
        in_data_a = DATA_A;
        mode_b = 1'b0; in_valid_b = 3'b000; out_ready_b = 1'b0;
        in_data_b = {8'hC2, 8'hB1, 8'hA0};
        reset_models();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid_a), 64'(0));
        check("rst_data",  64'(out_data_a),  64'(0));
        check("rst_sel",   64'(out_sel_a),   64'(0));
        check("rst_ptr",   64'(dut_a.ptr),   64'(0));

        // Idle: no requests for five cycles
        for (int i = 0; i < 5; i++) cycle("idle");

        // Directed vector table on the N=4 instance
        for (int i = 0; i < 21; i++) begin
            set_a(vecs[i].mode, vecs[i].valid, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d_ready", i), 64'(in_ready_a), 64'(vecs[i].ready));
            @(posedge clk);
            #1;
            update_models();
            check($sformatf("vec%0d_valid", i), 64'(out_valid_a), 64'(vecs[i].ov));
            check($sformatf("vec%0d_data", i),  64'(out_data_a),  64'(vecs[i].od));
            check($sformatf("vec%0d_sel", i),   64'(out_sel_a),   64'(vecs[i].os));
            check($sformatf("vec%0d_ptr", i),   64'(dut_a.ptr),   64'(vecs[i].ptr));
        end

        // Backpressure hold, then same-edge drain and reload
        in_data_a[95:64] = 32'hA5A5A5A5;
        set_a(1'b0, 4'b0100, 1'b0);
        cycle("bp_load");
        check("bp_load_data", 64'(out_data_a), 64'(32'hA5A5A5A5));
        set_a(1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            check("bp_hold_ready", 64'(in_ready_a), 64'(0));
            check("bp_hold_data",  64'(out_data_a), 64'(32'hA5A5A5A5));
        end
        set_a(1'b0, 4'b0001, 1'b1);
        cycle("bp_reload");
        check("bp_reload_sel",   64'(out_sel_a),   64'(0));
        check("bp_reload_valid", 64'(out_valid_a), 64'(1));
        set_a(1'b0, 4'b0000, 1'b1);
        in_data_a = DATA_A;
        cycle("bp_drain");

        // N=3 pointer wrap: ch2 then ch0
        mode_b = 1'b1; out_ready_b = 1'b1; in_valid_b = 3'b100;
        cycle("n3_ch2");
        check("n3_ch2_sel", 64'(out_sel_b), 64'(2));
        check("n3_ch2_ptr", 64'(dut_b.ptr), 64'(0));
        in_valid_b = 3'b001;
        cycle("n3_ch0");
        check("n3_ch0_sel", 64'(out_sel_b), 64'(0));
        check("n3_ch0_ptr", 64'(dut_b.ptr), 64'(1));
        in_valid_b = 3'b000;
        cycle("n3_idle");

        // Asynchronous reset mid-cycle with a word held
        set_a(1'b1, 4'b0010, 1'b0);
        cycle("ar_load");
        check("ar_load_valid", 64'(out_valid_a), 64'(1));
        set_a(1'b1, 4'b1111, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid_a), 64'(0));
        check("ar_data",  64'(out_data_a),  64'(0));
        check("ar_ptr",   64'(dut_a.ptr),   64'(0));
        check("ar_ready", 64'(in_ready_a),  64'(0));
        reset_models();
        @(posedge clk);
        in_valid_a = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_a(1'b1, 4'b1111, 1'b1);
        cycle("ar_resume");
        check("ar_resume_sel", 64'(out_sel_a), 64'(0));

        // Randomized traffic on both instances against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 7) == 0) mode_b = ~mode_b;
            in_valid_a  = 4'($urandom);
            in_data_a   = {$urandom, $urandom, $urandom, $urandom};
            out_ready_a = ($urandom_range(0, 3) != 0);
            in_valid_b  = 3'($urandom);
            in_data_b   = 24'($urandom);
            out_ready_b = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
